// File: rtl/dkong_vram_arbiter.sv
// Single-port VRAM arbiter: video fetch has fixed priority, CPU and debug loader share the
// remaining slots round-robin. Every access completes a fixed two cycles after its grant.
module dkong_vram_arbiter #(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned WAIT_LIMIT = 64
) (
    input  logic              masterclk,
    input  logic              rst_n,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [DATA_W-1:0] vid_rdata,
    output logic              vid_rvalid,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_wait_n,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_ack,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [1:0]        grant_owner,
    output logic              cpu_starved
);

    localparam int unsigned CntW = $clog2(WAIT_LIMIT + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(WAIT_LIMIT);

    typedef enum logic [1:0] {
        OwnIdle = 2'd0,
        OwnVid  = 2'd1,
        OwnCpu  = 2'd2,
        OwnDbg  = 2'd3
    } owner_e;

    owner_e            sel;
    owner_e            owner_q;
    owner_e            p1_owner_q;
    logic              p1_we_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic              ram_we_q;
    logic [DATA_W-1:0] ram_wdata_q;
    logic              rr_last_dbg_q;
    logic              cpu_busy_q;
    logic              dbg_busy_q;
    logic              vid_rvalid_q;
    logic              cpu_ack_q;
    logic              dbg_ack_q;
    logic [DATA_W-1:0] vid_rdata_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] dbg_rdata_q;
    logic [CntW-1:0]   wait_cnt_q;
    logic              cpu_elig;
    logic              dbg_elig;

    // Busy flags stay set through the ack cycle so a still-high req is not granted twice.
    assign cpu_elig = cpu_req & ~cpu_busy_q;
    assign dbg_elig = dbg_req & ~dbg_busy_q;

    always_comb begin
        sel = OwnIdle;
        if (vid_req) begin
            sel = OwnVid;
        end else if (cpu_elig && dbg_elig) begin
            sel = rr_last_dbg_q ? OwnCpu : OwnDbg;
        end else if (cpu_elig) begin
            sel = OwnCpu;
        end else if (dbg_elig) begin
            sel = OwnDbg;
        end
    end

    always_ff @(posedge masterclk) begin
        if (!rst_n) begin
            owner_q       <= OwnIdle;
            p1_owner_q    <= OwnIdle;
            p1_we_q       <= 1'b0;
            ram_addr_q    <= '0;
            ram_we_q      <= 1'b0;
            ram_wdata_q   <= '0;
            rr_last_dbg_q <= 1'b1;
            cpu_busy_q    <= 1'b0;
            dbg_busy_q    <= 1'b0;
            vid_rvalid_q  <= 1'b0;
            cpu_ack_q     <= 1'b0;
            dbg_ack_q     <= 1'b0;
            vid_rdata_q   <= '0;
            cpu_rdata_q   <= '0;
            dbg_rdata_q   <= '0;
            wait_cnt_q    <= '0;
        end else begin
            owner_q <= sel;
            unique case (sel)
                OwnVid: begin
                    ram_addr_q <= vid_addr;
                    ram_we_q   <= 1'b0;
                end
                OwnCpu: begin
                    ram_addr_q    <= cpu_addr;
                    ram_we_q      <= cpu_we;
                    ram_wdata_q   <= cpu_wdata;
                    rr_last_dbg_q <= 1'b0;
                end
                OwnDbg: begin
                    ram_addr_q    <= dbg_addr;
                    ram_we_q      <= dbg_we;
                    ram_wdata_q   <= dbg_wdata;
                    rr_last_dbg_q <= 1'b1;
                end
                default: ram_we_q <= 1'b0;
            endcase

            cpu_busy_q <= (sel == OwnCpu) | (cpu_busy_q & ~cpu_ack_q);
            dbg_busy_q <= (sel == OwnDbg) | (dbg_busy_q & ~dbg_ack_q);

            // RAM samples the slot one edge after grant; its data is captured the edge after.
            p1_owner_q   <= owner_q;
            p1_we_q      <= ram_we_q;
            vid_rvalid_q <= (p1_owner_q == OwnVid);
            cpu_ack_q    <= (p1_owner_q == OwnCpu);
            dbg_ack_q    <= (p1_owner_q == OwnDbg);
            if (p1_owner_q == OwnVid) vid_rdata_q <= ram_rdata;
            if (p1_owner_q == OwnCpu && !p1_we_q) cpu_rdata_q <= ram_rdata;
            if (p1_owner_q == OwnDbg && !p1_we_q) dbg_rdata_q <= ram_rdata;

            if (!cpu_req || sel == OwnCpu) begin
                wait_cnt_q <= '0;
            end else if (!cpu_busy_q && wait_cnt_q != CntMax) begin
                wait_cnt_q <= wait_cnt_q + CntW'(1);
            end
        end
    end

    assign grant_owner = owner_q;
    assign ram_addr    = ram_addr_q;
    assign ram_we      = ram_we_q;
    assign ram_wdata   = ram_wdata_q;
    assign vid_rvalid  = vid_rvalid_q;
    assign vid_rdata   = vid_rdata_q;
    assign cpu_ack     = cpu_ack_q;
    assign cpu_rdata   = cpu_rdata_q;
    assign dbg_ack     = dbg_ack_q;
    assign dbg_rdata   = dbg_rdata_q;
    assign cpu_wait_n  = ~(cpu_req & ~cpu_ack_q);
    assign cpu_starved = (wait_cnt_q == CntMax);

endmodule

// File: tb/tb_dkong_vram_arbiter.sv
// Directed bench for dkong_vram_arbiter with a behavioural single-port RAM whose unwritten
// locations read back as addr[7:0].
module tb_dkong_vram_arbiter;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DATA_W = 8;

    logic              masterclk = 1'b0;
    logic              rst_n = 1'b0;
    logic              vid_req = 1'b0;
    logic [ADDR_W-1:0] vid_addr = '0;
    logic [DATA_W-1:0] vid_rdata;
    logic              vid_rvalid;
    logic              cpu_req = 1'b0;
    logic              cpu_we = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [DATA_W-1:0] cpu_wdata = '0;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ack;
    logic              cpu_wait_n;
    logic              dbg_req = 1'b0;
    logic              dbg_we = 1'b0;
    logic [ADDR_W-1:0] dbg_addr = '0;
    logic [DATA_W-1:0] dbg_wdata = '0;
    logic [DATA_W-1:0] dbg_rdata;
    logic              dbg_ack;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata = '0;
    logic [1:0]        grant_owner;
    logic              cpu_starved;

    int tests_run = 0;
    int tests_failed = 0;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    bit                written [0:(1<<ADDR_W)-1];

    dkong_vram_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_LIMIT(64)
    ) dut (
        .masterclk(masterclk), .rst_n(rst_n),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_rdata(vid_rdata), .vid_rvalid(vid_rvalid),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_wait_n(cpu_wait_n),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .grant_owner(grant_owner), .cpu_starved(cpu_starved)
    );

    always #5 masterclk = ~masterclk;

    // Read-first synchronous RAM.
    always @(posedge masterclk) begin
        ram_rdata <= written[ram_addr] ? mem[ram_addr] : ram_addr[7:0];
        if (ram_we) begin
            mem[ram_addr]     <= ram_wdata;
            written[ram_addr] <= 1'b1;
        end
    end

    task automatic tick;
        @(posedge masterclk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0; vid_req = 1'b0; cpu_req = 1'b0; dbg_req = 1'b0;
        cpu_we = 1'b0; dbg_we = 1'b0;
        tick; tick;
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; vid_req = 1'b1; cpu_req = 1'b1; dbg_req = 1'b1;
        repeat (3) tick;
        tests_run++;
        if ({vid_rvalid, cpu_ack, dbg_ack} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_acks got %b want 000", {vid_rvalid, cpu_ack, dbg_ack});
        end
        tests_run++;
        if (grant_owner !== 2'd0 || ram_we !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_grant got owner=%0d we=%b want 0/0", grant_owner, ram_we);
        end
        tests_run++;
        if (cpu_wait_n !== 1'b0 || cpu_starved !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_wait got wait_n=%b starved=%b want 0/0", cpu_wait_n, cpu_starved);
        end
        rst_n = 1'b1;
        tick;
        tests_run++;
        if (grant_owner !== 2'd1 || ram_we !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_first_slot got owner=%0d we=%b want 1/0", grant_owner, ram_we);
        end
        vid_req = 1'b0; cpu_req = 1'b0; dbg_req = 1'b0;
        repeat (4) tick;
    endtask

    task automatic test_video_stream;
        for (int c = 0; c < 12; c++) begin
            vid_req  = (c < 8);
            vid_addr = ADDR_W'(c);
            tick;
            if (c < 8) begin
                tests_run++;
                if (grant_owner !== 2'd1 || ram_addr !== ADDR_W'(c)) begin
                    tests_failed++;
                    $display("FAIL vid_grant[%0d] got owner=%0d addr=%h want 1/%h",
                             c, grant_owner, ram_addr, c);
                end
            end
            tests_run++;
            if (vid_rvalid !== (c >= 2 && c < 10)) begin
                tests_failed++;
                $display("FAIL vid_rvalid[%0d] got %b want %b", c, vid_rvalid, (c >= 2 && c < 10));
            end
            if (c >= 2 && c < 10) begin
                tests_run++;
                if (vid_rdata !== DATA_W'(c - 2)) begin
                    tests_failed++;
                    $display("FAIL vid_rdata[%0d] got %h want %h", c, vid_rdata, c - 2);
                end
            end
        end
    endtask

    task automatic test_cpu_write_read;
        do_reset;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h123; cpu_wdata = 8'hA5;
        #1;
        tests_run++;
        if (cpu_wait_n !== 1'b0) begin
            tests_failed++;
            $display("FAIL cpu_wait_pending got %b want 0", cpu_wait_n);
        end
        tick; // E
        tests_run++;
        if (grant_owner !== 2'd2 || ram_we !== 1'b1 || ram_addr !== 10'h123 || ram_wdata !== 8'hA5)
        begin
            tests_failed++;
            $display("FAIL cpu_wr_grant got owner=%0d we=%b addr=%h wdata=%h want 2/1/123/a5",
                     grant_owner, ram_we, ram_addr, ram_wdata);
        end
        tick; // E+1
        tests_run++;
        if (cpu_ack !== 1'b0 || cpu_wait_n !== 1'b0) begin
            tests_failed++;
            $display("FAIL cpu_wr_e1 got ack=%b wait_n=%b want 0/0", cpu_ack, cpu_wait_n);
        end
        tick; // E+2
        tests_run++;
        if (cpu_ack !== 1'b1 || cpu_wait_n !== 1'b1 || cpu_rdata !== 8'h00) begin
            tests_failed++;
            $display("FAIL cpu_wr_ack got ack=%b wait_n=%b rdata=%h want 1/1/00",
                     cpu_ack, cpu_wait_n, cpu_rdata);
        end
        cpu_we = 1'b0;
        tick; // E+3: still in flight, no grant
        tests_run++;
        if (grant_owner !== 2'd0 || ram_we !== 1'b0 || ram_addr !== 10'h123 || cpu_wait_n !== 1'b0)
        begin
            tests_failed++;
            $display("FAIL cpu_e3_idle got owner=%0d we=%b addr=%h wait_n=%b want 0/0/123/0",
                     grant_owner, ram_we, ram_addr, cpu_wait_n);
        end
        tick; // E+4
        tests_run++;
        if (grant_owner !== 2'd2 || ram_we !== 1'b0) begin
            tests_failed++;
            $display("FAIL cpu_rd_grant got owner=%0d we=%b want 2/0", grant_owner, ram_we);
        end
        tick; tick; // E+6
        tests_run++;
        if (cpu_ack !== 1'b1 || cpu_rdata !== 8'hA5) begin
            tests_failed++;
            $display("FAIL cpu_rd_ack got ack=%b rdata=%h want 1/a5", cpu_ack, cpu_rdata);
        end
        cpu_req = 1'b0;
        repeat (2) tick;
    endtask

    task automatic test_round_robin;
        logic [1:0] exp_owner [8];
        logic       exp_cack [8];
        logic       exp_dack [8];
        exp_owner = '{2'd2, 2'd3, 2'd0, 2'd0, 2'd2, 2'd3, 2'd0, 2'd0};
        exp_cack  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        exp_dack  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        do_reset;
        cpu_addr = 10'h010; dbg_addr = 10'h045;
        cpu_req = 1'b1; dbg_req = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick;
            tests_run++;
            if (grant_owner !== exp_owner[k] || cpu_ack !== exp_cack[k] || dbg_ack !== exp_dack[k])
            begin
                tests_failed++;
                $display("FAIL rr[%0d] got owner=%0d cack=%b dack=%b want %0d/%b/%b", k,
                         grant_owner, cpu_ack, dbg_ack, exp_owner[k], exp_cack[k], exp_dack[k]);
            end
        end
        tests_run++;
        if (cpu_rdata !== 8'h10 || dbg_rdata !== 8'h45) begin
            tests_failed++;
            $display("FAIL rr_rdata got cpu=%h dbg=%h want 10/45", cpu_rdata, dbg_rdata);
        end
        cpu_req = 1'b0; dbg_req = 1'b0;
        repeat (3) tick;
    endtask

    task automatic test_starvation;
        do_reset;
        vid_req = 1'b1; vid_addr = 10'h000;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h020;
        for (int k = 1; k <= 70; k++) begin
            tick;
            tests_run++;
            if (grant_owner !== 2'd1 || cpu_starved !== (k >= 64)) begin
                tests_failed++;
                $display("FAIL starve[%0d] got owner=%0d starved=%b want 1/%b",
                         k, grant_owner, cpu_starved, (k >= 64));
            end
        end
        vid_req = 1'b0;
        tick;
        tests_run++;
        if (grant_owner !== 2'd2 || cpu_starved !== 1'b0) begin
            tests_failed++;
            $display("FAIL starve_grant got owner=%0d starved=%b want 2/0", grant_owner, cpu_starved);
        end
        tick; tick;
        tests_run++;
        if (cpu_ack !== 1'b1 || cpu_rdata !== 8'h20) begin
            tests_failed++;
            $display("FAIL starve_ack got ack=%b rdata=%h want 1/20", cpu_ack, cpu_rdata);
        end
        cpu_req = 1'b0;
        repeat (2) tick;
    endtask

    task automatic test_reset_mid_txn;
        do_reset;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h030;
        tick; // E
        tests_run++;
        if (grant_owner !== 2'd2) begin
            tests_failed++;
            $display("FAIL midrst_grant got owner=%0d want 2", grant_owner);
        end
        rst_n = 1'b0;
        tick; // E+1 in reset
        tests_run++;
        if (cpu_ack !== 1'b0 || grant_owner !== 2'd0) begin
            tests_failed++;
            $display("FAIL midrst_e1 got ack=%b owner=%0d want 0/0", cpu_ack, grant_owner);
        end
        rst_n = 1'b1;
        tick; // E+2: old ack suppressed, fresh grant
        tests_run++;
        if (cpu_ack !== 1'b0 || grant_owner !== 2'd2) begin
            tests_failed++;
            $display("FAIL midrst_e2 got ack=%b owner=%0d want 0/2", cpu_ack, grant_owner);
        end
        tick; // E+3
        tests_run++;
        if (cpu_ack !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_e3 got ack=%b want 0", cpu_ack);
        end
        tick; // E+4
        tests_run++;
        if (cpu_ack !== 1'b1 || cpu_rdata !== 8'h30) begin
            tests_failed++;
            $display("FAIL midrst_ack got ack=%b rdata=%h want 1/30", cpu_ack, cpu_rdata);
        end
        cpu_req = 1'b0;
        repeat (2) tick;
    endtask

    initial begin
        test_reset;
        test_video_stream;
        test_cpu_write_read;
        test_round_robin;
        test_starvation;
        test_reset_mid_txn;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "timeout");
    end

endmodule
